bpsk_bit_serializer: RTL and testbench
======================================

BPSK_BIT_SERIALIZER -- requirements
Module: bpsk_bit_serializer

Interface
- REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: bits per input word, legal range 1..32.
- REQ-002 The block SHALL have parameter SYM_CLKS, default 16: clock cycles per transmitted symbol, legal range 2..65535.
- REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
- REQ-005 The block SHALL have port in_data, input, DATA_WIDTH bits: parallel word to transmit.
- REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
- REQ-007 The block SHALL have port in_ready, output, 1 bit: block accepts a word this cycle.
- REQ-008 The block SHALL have port sel, output, 1 bit: current symbol bit, driving the select of the downstream carrier/inverted-carrier 2:1 mux.
- REQ-009 The block SHALL have port busy, output, 1 bit: a word is being serialized.
- REQ-010 The block SHALL have port sym_start, output, 1 bit: one-cycle pulse in the first cycle of each symbol.
- REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse in the last cycle of a word's final symbol.

Function
- REQ-012 The block SHALL implement two states: IDLE and SHIFT.
- REQ-013 The block SHALL accept a word only on a rising edge where in_valid=1 and in_ready=1 (a transfer); it SHALL ignore in_data at all other times.
- REQ-014 On a transfer, the block SHALL load a DATA_WIDTH-bit shift register with in_data, clear the symbol counter and bit counter to 0, and enter SHIFT.
- REQ-015 While in IDLE, the block SHALL drive in_ready=1.
- REQ-016 While in SHIFT, the block SHALL drive in_ready=1 only in the last cycle of the final symbol (bit_cnt=DATA_WIDTH-1 and sym_cnt=SYM_CLKS-1); it SHALL drive 0 otherwise.
- REQ-017 The block SHALL drive busy=1 exactly when in state SHIFT.
- REQ-018 In SHIFT, the block SHALL drive sel equal to the shift register MSB, so bits go out MSB first; in IDLE it SHALL drive sel=0.
- REQ-019 In SHIFT, the symbol counter SHALL increment every cycle and wrap from SYM_CLKS-1 to 0.
- REQ-020 On each symbol-counter wrap, the block SHALL shift the register left by one (LSB filled with 0) and increment the bit counter.
- REQ-021 The block SHALL hold each bit on sel for exactly SYM_CLKS cycles.
- REQ-022 A word SHALL occupy exactly DATA_WIDTH*SYM_CLKS cycles in SHIFT.
- REQ-023 The first sel bit SHALL appear in the cycle after the transfer edge, so latency is 1 cycle.
- REQ-024 The block SHALL assert sym_start=1 whenever state=SHIFT and sym_cnt=0.
- REQ-025 The block SHALL assert frame_done=1 whenever state=SHIFT, bit_cnt=DATA_WIDTH-1 and sym_cnt=SYM_CLKS-1.
- REQ-026 At frame end with a simultaneous transfer (in_valid=1 during the frame_done cycle), the block SHALL load the new word and stay in SHIFT with no gap cycle: the new MSB appears next cycle and sym_start pulses next cycle.
- REQ-027 At frame end without in_valid, the block SHALL return to IDLE, so the next cycle has busy=0, sel=0 and in_ready=1.
- REQ-028 The symbol counter SHALL be sized clog2(SYM_CLKS) bits and the bit counter clog2(DATA_WIDTH) bits, each minimum 1 bit.
- REQ-029 Neither counter SHALL exceed its terminal count.
- REQ-030 For DATA_WIDTH=1, the block SHALL treat each word as a single symbol, so frame_done coincides with the last cycle of that symbol.
- REQ-031 The block SHALL produce no combinational path from in_data to any output.
- REQ-032 The in_valid-to-in_ready path SHALL NOT be combinational; in_ready depends on state only.

Reset
- REQ-033 While rst=1 at a rising edge, the block SHALL enter IDLE and clear the shift register, symbol counter and bit counter to 0, regardless of in_valid.
- REQ-034 After reset, the block SHALL drive sel=0, busy=0, sym_start=0, frame_done=0 and in_ready=1.
- REQ-035 A reset mid-word SHALL discard the word with no frame_done pulse.
- REQ-036 A transfer coincident with rst=1 SHALL be discarded.

Verification
(All scenarios use DATA_WIDTH=8 and SYM_CLKS=4.)
- REQ-037 Reset scenario: hold rst for 3 cycles with in_valid=1 and in_data=0xFF -> every cycle after reset shows sel=0, busy=0, in_ready=1, and no pulses.
- REQ-038 Single word: transfer 0xA5 then drop in_valid -> sel holds each of 1,0,1,0,0,1,0,1 for 4 cycles starting the next cycle; sym_start pulses 8 times at 4-cycle spacing; frame_done pulses in cycle 32; busy falls in cycle 33.
- REQ-039 Back-to-back: hold in_valid=1, present 0xFF then 0x00 at the frame_done cycle -> sel=1 for 32 cycles then sel=0 for 32 cycles with no gap; busy stays 1 for 64 cycles.
- REQ-040 Mid-frame valid: during 0x80, assert in_valid with 0x3C from cycle 5 -> in_ready=0 until cycle 32; 0x3C is accepted at the cycle-32 edge; its sel sequence 0,0,1,1,1,1,0,0 starts at cycle 33.
- REQ-041 Reset mid-operation: assert rst at cycle 10 of 0xF0 -> next cycle shows busy=0, sel=0, in_ready=1; no frame_done pulse; a new word 0x01 afterwards serializes correctly.

Source files
------------

// File: rtl/bpsk_bit_serializer.sv
// bpsk_bit_serializer: shifts parallel words out MSB first as SYM_CLKS-cycle symbols on sel.
module bpsk_bit_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int SYM_CLKS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  sel,
    output logic                  busy,
    output logic                  sym_start,
    output logic                  frame_done
);
    localparam int SW = (SYM_CLKS > 1) ? $clog2(SYM_CLKS) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [SW-1:0]         r_sym;
    logic [BW-1:0]         r_bit;
    logic                  w_sym_last, w_bit_last, w_end, w_ready, w_xfer;

    assign w_sym_last = r_sym == SW'(SYM_CLKS - 1);
    assign w_bit_last = r_bit == BW'(DATA_WIDTH - 1);
    assign w_end      = (r_state == SHIFT) && w_sym_last && w_bit_last;
    // ready depends only on registered state so in_valid never loops back combinationally
    assign w_ready    = (r_state == IDLE) || w_end;
    assign w_xfer     = in_valid && w_ready;

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next     = w_xfer ? SHIFT : (w_end ? IDLE : r_state);
        in_ready   = w_ready;
        busy       = r_state == SHIFT;
        sel        = (r_state == SHIFT) && r_shift[DATA_WIDTH-1];
        sym_start  = (r_state == SHIFT) && (r_sym == '0);
        frame_done = w_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_sym   <= '0;
            r_bit   <= '0;
        end else if (w_xfer) begin
            r_shift <= in_data;
            r_sym   <= '0;
            r_bit   <= '0;
        end else if (r_state == SHIFT) begin
            r_sym <= w_sym_last ? '0 : r_sym + SW'(1);
            if (w_sym_last) begin
                r_shift <= r_shift << 1;
                r_bit   <= w_bit_last ? '0 : r_bit + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_bpsk_bit_serializer.sv
// tb_bpsk_bit_serializer: directed vectors; expected per-cycle outputs queued, checked by a negedge monitor.
module tb_bpsk_bit_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'hFF;
    logic       in_valid = 1'b1;
    logic       in_ready, sel, busy, sym_start, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    logic [4:0] exp_q[$];

    localparam logic [4:0] IDLE_EXP = 5'b00100;

    bpsk_bit_serializer #(.DATA_WIDTH(8), .SYM_CLKS(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .busy(busy),
        .sym_start(sym_start), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // monitor: {sel, busy, in_ready, sym_start, frame_done}
    always @(negedge clk) begin
        cyc_no <= cyc_no + 1;
        if (exp_q.size() > 0) begin
            logic [4:0] e, g;
            e = exp_q.pop_front();
            g = {sel, busy, in_ready, sym_start, frame_done};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got sel/busy/rdy/ss/fd=%b expected %b", cyc_no, g, e);
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic chk, input logic [4:0] e);
        rst = r;
        in_valid = v;
        in_data = d;
        if (chk) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // frame cycle k (0..31) of word w: bit w[7-k/4] held 4 cycles, ready/frame_done only at k=31
    task automatic frame(input logic [7:0] w, input int n, input int vstart,
                         input logic [7:0] dmid, input logic [7:0] dnext, input int rst_k);
        for (int k = 0; k < n; k++)
            cyc(k == rst_k, k >= vstart, (k == 31) ? dnext : dmid, 1'b1,
                {w[7 - k / 4], 1'b1, k == 31, (k % 4) == 0, k == 31});
    endtask

    initial begin
        // reset held with a pending transfer
        cyc(1, 1, 8'hFF, 0, IDLE_EXP);
        cyc(1, 1, 8'hFF, 1, IDLE_EXP);
        cyc(1, 1, 8'hFF, 1, IDLE_EXP);
        cyc(0, 0, 8'h00, 1, IDLE_EXP);
        cyc(0, 0, 8'h00, 1, IDLE_EXP);
        // single word 0xA5
        cyc(0, 1, 8'hA5, 1, IDLE_EXP);
        frame(8'hA5, 32, 32, 8'h00, 8'h00, -1);
        cyc(0, 0, 8'h00, 1, IDLE_EXP);
        // back-to-back 0xFF then 0x00
        cyc(0, 1, 8'hFF, 1, IDLE_EXP);
        frame(8'hFF, 32, 0, 8'hFF, 8'h00, -1);
        frame(8'h00, 32, 32, 8'h00, 8'h00, -1);
        cyc(0, 0, 8'h00, 1, IDLE_EXP);
        // 0x3C offered from cycle 5 of 0x80, taken only at its frame end
        cyc(0, 1, 8'h80, 1, IDLE_EXP);
        frame(8'h80, 32, 4, 8'h3C, 8'h3C, -1);
        frame(8'h3C, 32, 32, 8'h00, 8'h00, -1);
        cyc(0, 0, 8'h00, 1, IDLE_EXP);
        // reset in cycle 10 of 0xF0, then 0x01
        cyc(0, 1, 8'hF0, 1, IDLE_EXP);
        frame(8'hF0, 10, 32, 8'h00, 8'h00, 9);
        cyc(0, 0, 8'h00, 1, IDLE_EXP);
        cyc(0, 0, 8'h00, 1, IDLE_EXP);
        cyc(0, 1, 8'h01, 1, IDLE_EXP);
        frame(8'h01, 32, 32, 8'h00, 8'h00, -1);
        cyc(0, 0, 8'h00, 1, IDLE_EXP);
        cyc(0, 0, 8'h00, 1, IDLE_EXP);
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
